// File: rtl/a2d_arbiter.sv
// Two-requester round-robin arbiter sharing one SPI A2D converter.
// One conversion per grant, a registered result and done pulse, and a watchdog on WAIT.
module a2d_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [2:0]  chnnl0,
    input  logic        req1,
    input  logic [2:0]  chnnl1,
    output logic        done0,
    output logic        done1,
    output logic [11:0] res_out,
    output logic        busy,
    output logic        timeout,
    output logic        a2d_strt_cnv,
    output logic [2:0]  a2d_chnnl,
    input  logic        a2d_cnv_cmplt,
    input  logic [11:0] a2d_res,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      r_state;
    logic        r_owner;
    logic        r_ptr;
    logic [15:0] r_cnt;
    logic        r_done0;
    logic        r_done1;
    logic [11:0] r_res;
    logic        r_timeout;
    logic [2:0]  r_chnnl;

    state_t      w_state_nxt;
    logic        w_owner_nxt;
    logic        w_ptr_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_done0_nxt;
    logic        w_done1_nxt;
    logic [11:0] w_res_nxt;
    logic        w_timeout_nxt;
    logic [2:0]  w_chnnl_nxt;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_pick1;

    // A requester still holding req during its own done pulse is not yet eligible again.
    assign w_elig0 = req0 & ~r_done0;
    assign w_elig1 = req1 & ~r_done1;
    assign w_pick1 = w_elig1 & (~w_elig0 | r_ptr);

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_done0_nxt   = 1'b0;
        w_done1_nxt   = 1'b0;
        w_res_nxt     = r_res;
        w_timeout_nxt = r_timeout;
        w_chnnl_nxt   = r_chnnl;
        case (r_state)
            S_IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_owner_nxt = w_pick1;
                    w_chnnl_nxt = w_pick1 ? chnnl1 : chnnl0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt   = 16'd0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes precedence over a watchdog expiry in the same cycle.
                if (a2d_cnv_cmplt) begin
                    w_res_nxt   = a2d_res;
                    w_done0_nxt = ~r_owner;
                    w_done1_nxt = r_owner;
                    w_ptr_nxt   = ~r_owner;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_res_nxt     = 12'h000;
                    w_done0_nxt   = ~r_owner;
                    w_done1_nxt   = r_owner;
                    w_timeout_nxt = 1'b1;
                    w_ptr_nxt     = ~r_owner;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_ptr     <= 1'b0;
            r_cnt     <= 16'd0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_res     <= 12'h000;
            r_timeout <= 1'b0;
            r_chnnl   <= 3'b000;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done0   <= w_done0_nxt;
            r_done1   <= w_done1_nxt;
            r_res     <= w_res_nxt;
            r_timeout <= w_timeout_nxt;
            r_chnnl   <= w_chnnl_nxt;
        end
    end

    assign done0        = r_done0;
    assign done1        = r_done1;
    assign res_out      = r_res;
    assign busy         = (r_state != S_IDLE);
    assign timeout      = r_timeout;
    assign a2d_strt_cnv = (r_state == S_START);
    assign a2d_chnnl    = r_chnnl;
    assign dbg_state    = r_state;

endmodule

// File: doc/a2d_arbiter.md
Name: a2d_arbiter

Overview:
Two-requester round-robin arbiter that shares the single SPI A2D converter interface. Requester 0 is the IR line-sensor scan sequencer; requester 1 is the housekeeping monitor (battery and other analog channels). The arbiter sequences one conversion per grant: it drives strt_cnv and chnnl into the A2D interface, waits for cnv_cmplt, and returns the 12-bit result to the owning requester. A watchdog guards against a hung conversion.

Parameters:
TIMEOUT_CYC, 4096, number of WAIT-state cycles without cnv_cmplt before the conversion is aborted (range 2..65535).

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, reset is synchronous and active-high
req0  input  1  requester 0 conversion request, level; held until done0
chnnl0  input  3  requester 0 channel; stable while req0 high
req1  input  1  requester 1 conversion request, level; held until done1
chnnl1  input  3  requester 1 channel; stable while req1 high
done0  output  1  one-cycle pulse; res_out valid for requester 0
done1  output  1  one-cycle pulse; res_out valid for requester 1
res_out  output  12  last conversion result; held until next done
busy  output  1  high whenever state != IDLE
timeout  output  1  sticky watchdog error flag; cleared only by rst
a2d_strt_cnv  output  1  start pulse to A2D interface
a2d_chnnl  output  3  channel to A2D interface; registered, stable from START through WAIT
a2d_cnv_cmplt  input  1  conversion complete from A2D interface
a2d_res  input  12  conversion result from A2D interface

Behaviour:
- Reset values: state IDLE, done0/done1 0, res_out 12'h000, timeout 0, a2d_strt_cnv 0, a2d_chnnl 3'b000, priority pointer 0, watchdog counter 0.
- States: IDLE, START, WAIT.
- IDLE, eligibility: req_k is eligible unless done_k is high in the same cycle. This masks the requester that has not yet dropped req after its done pulse.
- IDLE, one eligible request: latch its owner and channel (a2d_chnnl <= chnnl_k), go to START.
- IDLE, both eligible: the owner is the requester indicated by the priority pointer.
- IDLE, no eligible request: stay in IDLE.
- START: a2d_strt_cnv = 1 for exactly this one cycle; watchdog counter <= 0; go to WAIT.
- WAIT, a2d_cnv_cmplt = 1:
  - res_out <= a2d_res and done_owner <= 1, both registered, so they are visible the cycle after cmplt.
  - Priority pointer <= the other requester.
  - Go to IDLE.
- WAIT, no cmplt and counter == TIMEOUT_CYC-1:
  - res_out <= 12'h000, done_owner <= 1, timeout <= 1.
  - Priority pointer flips; go to IDLE.
- WAIT, otherwise: counter increments (16-bit, no wrap reachable).
- cmplt and timeout in the same cycle: cmplt wins; timeout is not set.
- a2d_cnv_cmplt in IDLE or START is ignored; a stale completion after reset or timeout is discarded.
- done pulses last exactly one cycle (registered, self-clearing). At most one of done0/done1 is high in any cycle.
- Latency: request first eligible in IDLE cycle N gives strt_cnv high in cycle N+1; cmplt in cycle M gives done and res_out in cycle M+1. Back-to-back grants are possible: a new START can occur in cycle M+2.
- Channel inputs are sampled only on the IDLE→START edge. Later changes do not affect an in-flight conversion.
- Fairness: with both requests continuously asserted, grants alternate 0,1,0,1…; neither requester is starved.
- rst asserted in any state: all outputs go to their reset values on the next edge and any in-flight conversion is dropped. The A2D interface is reset by its own reset.

Test Plan:
- Single request: req0=1, chnnl0=3'd5, then cmplt with a2d_res=12'hABC two cycles after strt_cnv. Required: a2d_chnnl=5; one strt_cnv pulse one cycle after req; done0 and res_out=12'hABC one cycle after cmplt; no second grant while req0 is still high during done0.
- Simultaneous requests, both held for 4 conversions. Required: grant order 0,1,0,1 (owner 0 first after reset); each a2d_chnnl matches its owner's chnnl.
- Watchdog: grant req1, never assert cmplt, TIMEOUT_CYC=16. Required: done1 16 cycles after WAIT entry, res_out=12'h000, timeout=1 and sticky through later successful conversions until rst.
- cmplt and final watchdog cycle coincide. Required: res_out=a2d_res, timeout stays 0.
- Reset mid-WAIT: assert rst, then a stale cmplt arrives in IDLE. Required: all outputs at reset values, no done pulse, res_out=0, next req0 is granted normally.
- Channel change mid-conversion: chnnl0 changes from 2 to 7 during WAIT. Required: a2d_chnnl stays 2 until the next grant.
